alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//   Shares the single ALU of the processing element between NREQ requesters.
//   Each requester offers operands and a 3-bit ALUControl code; the arbiter grants one per cycle, round-robin.
//   It drives the shared combinational ALU's inputs and registers the ALU result.
//   It returns the result with the requester ID over a valid/ready response channel.
//   Sits between the PE lanes and the ALU, using the existing ALU_Decoder control encoding.
// PARAMETERS
//   NREQ   4   number of requesters (2..8)
//   WIDTH  32  operand/result width
// PORTS
//   clk          in   1             clock, all state on rising edge
//   rst          in   1             asynchronous, active-low reset
//   req_valid    in   NREQ          requester i has an operation pending
//   req_ready    out  NREQ          one-hot grant; op i accepted when req_valid[i]&req_ready[i]
//   req_a        in   NREQ*WIDTH    operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b        in   NREQ*WIDTH    operand B, same packing
//   req_ctrl     in   NREQ*3        ALUControl, requester i at [i*3 +: 3]
//   alu_a        out  WIDTH         to shared ALU SrcA
//   alu_b        out  WIDTH         to shared ALU SrcB
//   alu_ctrl     out  3             to shared ALU ALUControl
//   alu_result   in   WIDTH         from shared ALU, combinational in alu_a/alu_b/alu_ctrl
//   alu_zero     in   1             ALU zero flag
//   rsp_valid    out  1             response register holds a result
//   rsp_ready    in   1             consumer takes the result this cycle
//   rsp_result   out  WIDTH         registered ALU result
//   rsp_zero     out  1             registered zero flag
//   rsp_id       out  $clog2(NREQ)  index of the requester that issued the op
// BEHAVIOUR
//   - Reset (rst==0, async): rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, rr_ptr=0.
//     A held, undelivered result is discarded. req_ready=0 while rst==0.
//   - can_accept = !rsp_valid | rsp_ready (one-entry output register, drain and refill in the same cycle).
//   - Grant, combinational: if can_accept, search req_valid from index rr_ptr upward, wrapping at NREQ-1 -> 0.
//     The first set bit is g. req_ready = one-hot(g). req_ready=0 when there is no valid request or !can_accept.
//   - req_ready never depends on a requester's own req_valid except through the search (no ready-before-valid rule).
//   - Mux: when a grant exists, alu_a/alu_b/alu_ctrl = req_a/req_b/req_ctrl of g.
//     Otherwise all three are 0 (ctrl 3'b000 = add).
//   - Accept edge: rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_id<=g, rsp_valid<=1, rr_ptr<=(g+1) mod NREQ.
//   - Drain with no accept: rsp_valid<=0; rsp_result/rsp_zero/rsp_id hold their last values.
//   - Stall (rsp_valid & !rsp_ready): all rsp_* outputs hold stable, no grant, rr_ptr unchanged.
//   - Latency: accept in cycle N -> rsp_valid in cycle N+1. Throughput 1 op/cycle while rsp_ready=1.
//   - Fairness: a requester holding req_valid is granted within NREQ accepts.
//     rr_ptr changes only on an accept.
//   - Control codes are forwarded unchanged, including codes with no ALU meaning (110/111).
//     The arbiter does not decode them.
//   - Requester rules: operands must stay stable while req_valid is high and not yet granted.
//     A requester may drop req_valid before its grant without error.
// TESTING
//   1 Reset: rst=0 mid-stream with rsp_valid=1 -> rsp_valid=0 and rr_ptr=0 at once; first grant after release goes to lowest valid index.
//   2 Single op: req 2 a=5 b=3 ctrl=001, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=2, rsp_id=2, rsp_zero=0.
//   3 Round-robin: all 4 valid each cycle, rsp_ready=1 -> grant order 0,1,2,3,0,... one per cycle with no gaps.
//   4 Backpressure: rsp_ready=0 for 3 cycles with req 1 pending -> req_ready=0 and rsp_* unchanged for 3 cycles.
//     Grant on the cycle rsp_ready rises; new result next cycle.
//   5 Zero/SLT: a=7 b=7 ctrl=001 -> rsp_result=0, rsp_zero=1; a=-1 b=1 ctrl=101 -> rsp_result=1.
//   6 Wrap/skip: rr_ptr=3, valid={0,1 only} -> grant 0, then 1; a valid dropped before grant is never granted.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin arbiter that shares one combinational ALU between
// NREQ requesters. It drives the ALU inputs from the granted requester and
// registers the ALU result. The result is returned with the requester index over
// a one-entry valid/ready response register.
module alu_rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*3-1:0]     req_ctrl,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [2:0]            alu_ctrl,
   input  logic [WIDTH-1:0]      alu_result,
   input  logic                  alu_zero,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  rsp_zero,
   output logic [IDW-1:0]        rsp_id
);

   logic [IDW-1:0]   rr_ptr_r;
   logic             rsp_valid_r;
   logic [WIDTH-1:0] rsp_result_r;
   logic             rsp_zero_r;
   logic [IDW-1:0]   rsp_id_r;

   logic             can_accept_s;
   logic             grant_vld_s;
   logic [IDW-1:0]   grant_idx_s;
   logic [IDW-1:0]   next_ptr_s;

   // Requester index reached k steps after ptr, wrapping at NREQ-1 -> 0.
   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] ptr, input int k);
      int s;
      s = int'(ptr) + k;
      if (s >= NREQ) begin
         s = s - NREQ;
      end else begin
         s = s;
      end
      return s[IDW-1:0];
   endfunction

   // The output register can take a new result when it is empty or being drained;
   // nothing is granted while reset is asserted.
   assign can_accept_s = rst & (~rsp_valid_r | rsp_ready);

   // Round-robin search: the first valid requester at or after rr_ptr wins.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (can_accept_s && !grant_vld_s && req_valid[wrap_idx(rr_ptr_r, k)]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = wrap_idx(rr_ptr_r, k);
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
   end

   // One-hot grant plus the operand mux into the shared ALU (zeros when idle).
   always_comb begin
      req_ready = '0;
      alu_a     = '0;
      alu_b     = '0;
      alu_ctrl  = 3'b000;
      if (grant_vld_s) begin
         req_ready[grant_idx_s] = 1'b1;
         alu_a    = req_a[int'(grant_idx_s)*WIDTH +: WIDTH];
         alu_b    = req_b[int'(grant_idx_s)*WIDTH +: WIDTH];
         alu_ctrl = req_ctrl[int'(grant_idx_s)*3 +: 3];
      end else begin
         req_ready = '0;
      end
   end

   // Pointer moves to the requester just after the one that won.
   always_comb begin
      if (int'(grant_idx_s) == NREQ - 1) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_idx_s + {{(IDW-1){1'b0}}, 1'b1};
      end
   end

   // Response register and round-robin pointer; both change only on accept,
   // drain, or reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid_r  <= 1'b0;
         rsp_result_r <= '0;
         rsp_zero_r   <= 1'b0;
         rsp_id_r     <= '0;
         rr_ptr_r     <= '0;
      end else if (grant_vld_s) begin
         rsp_valid_r  <= 1'b1;
         rsp_result_r <= alu_result;
         rsp_zero_r   <= alu_zero;
         rsp_id_r     <= grant_idx_s;
         rr_ptr_r     <= next_ptr_s;
      end else begin
         rsp_valid_r  <= rsp_valid_r & ~rsp_ready;
      end
   end

   assign rsp_valid  = rsp_valid_r;
   assign rsp_result = rsp_result_r;
   assign rsp_zero   = rsp_zero_r;
   assign rsp_id     = rsp_id_r;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Testbench for alu_rr_arbiter: directed scenarios followed by a randomized phase,
// all checked against a behavioural model of the grant/response rules.
module tb_alu_rr_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 32;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*3-1:0]     req_ctrl;
   logic [WIDTH-1:0]      alu_a;
   logic [WIDTH-1:0]      alu_b;
   logic [2:0]            alu_ctrl;
   logic [WIDTH-1:0]      alu_result;
   logic                  alu_zero;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WIDTH-1:0]      rsp_result;
   logic                  rsp_zero;
   logic [1:0]            rsp_id;

   int compared   = 0;
   int mismatched = 0;

   // Behavioural model state
   int               m_ptr;
   logic             m_valid;
   logic [WIDTH-1:0] m_result;
   logic             m_zero;
   int               m_id;
   int               last_g;

   alu_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_id(rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU using the ALU_Decoder control encoding.
   function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [2:0] c);
      case (c)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return a ^ b;
         3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return a ^ ~b;
      endcase
   endfunction

   // Shared combinational ALU stub
   always_comb begin
      alu_result = ref_alu(alu_a, alu_b, alu_ctrl);
      alu_zero   = (alu_result == 32'd0);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_valid = 1'b0; m_result = '0; m_zero = 1'b0; m_id = 0;
   endtask

   // Winner by the round-robin rule: visit indices in rotated order starting at
   // the pointer and take the first one that is requesting; -1 if none.
   function automatic int model_grant();
      int order[$];
      if (!rst || !(!m_valid || rsp_ready)) return -1;
      for (int k = 0; k < NREQ; k++) order.push_back((m_ptr + k) % NREQ);
      foreach (order[j]) if (req_valid[order[j]]) return order[j];
      return -1;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [2:0] c);
      req_valid[i]            = v;
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_ctrl[i*3 +: 3]      = c;
   endtask

   // One clock: check grant/mux before the edge, advance model, check response after.
   task automatic tick();
      int g;
      logic [NREQ-1:0]  e_rdy;
      logic [WIDTH-1:0] ea, eb, er;
      logic [2:0]       ec;
      #1;
      g = model_grant();
      e_rdy = '0; ea = '0; eb = '0; ec = 3'b000;
      if (g >= 0) begin
         e_rdy[g] = 1'b1;
         ea = req_a[g*WIDTH +: WIDTH];
         eb = req_b[g*WIDTH +: WIDTH];
         ec = req_ctrl[g*3 +: 3];
      end
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("alu_a", 64'(alu_a), 64'(ea));
      chk("alu_b", 64'(alu_b), 64'(eb));
      chk("alu_ctrl", 64'(alu_ctrl), 64'(ec));
      @(posedge clk);
      if (!rst) model_reset();
      else if (g >= 0) begin
         er = ref_alu(ea, eb, ec);
         m_valid = 1'b1; m_result = er; m_zero = (er == 32'd0); m_id = g;
         m_ptr = (g + 1) % NREQ;
      end else if (rsp_ready) m_valid = 1'b0;
      last_g = g;
      #1;
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      chk("rsp_result", 64'(rsp_result), 64'(m_result));
      chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
   endtask

   initial begin
      rst = 1'b0; rsp_ready = 1'b1;
      req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0;
      last_g = -1;
      model_reset();
      req_valid = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_result", 64'(rsp_result), 64'd0);
      chk("reset_rsp_zero", 64'(rsp_zero), 64'd0);
      chk("reset_rsp_id", 64'(rsp_id), 64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      req_valid = '0;
      rst = 1'b1;

      // Single op: 5 - 3 from requester 2
      set_req(2, 1'b1, 32'd5, 32'd3, 3'b001);
      tick();
      chk("single_result", 64'(rsp_result), 64'd2);
      chk("single_id", 64'(rsp_id), 64'd2);
      chk("single_zero", 64'(rsp_zero), 64'd0);
      req_valid = '0;
      tick();

      // Mid-stream reset with a held result
      set_req(1, 1'b1, 32'd10, 32'd20, 3'b000);
      tick();
      chk("pre_reset_valid", 64'(rsp_valid), 64'd1);
      rst = 1'b0;
      #1;
      model_reset();
      chk("async_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("async_rsp_result", 64'(rsp_result), 64'd0);
      chk("async_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Round-robin with everyone requesting: first grant must go to index 0
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'(i * 100 + 1), 32'(i + 7), 3'(i));
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rr_order", 64'(rsp_id), 64'(k % NREQ));
      end

      // Backpressure with requester 1 pending
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_ready", 64'(req_ready), 64'd0);
         chk("stall_id", 64'(rsp_id), 64'd3);
         chk("stall_valid", 64'(rsp_valid), 64'd1);
      end
      rsp_ready = 1'b1;
      tick();
      chk("unstall_id", 64'(rsp_id), 64'd1);

      // Zero flag and signed set-less-than
      req_valid = '0;
      set_req(0, 1'b1, 32'd7, 32'd7, 3'b001);
      tick();
      chk("zero_result", 64'(rsp_result), 64'd0);
      chk("zero_flag", 64'(rsp_zero), 64'd1);
      set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b101);
      tick();
      chk("slt_result", 64'(rsp_result), 64'd1);
      chk("slt_zero", 64'(rsp_zero), 64'd0);

      // Wrap and skip: move pointer to 3, then only 0 and 1 request
      req_valid = '0;
      set_req(2, 1'b1, 32'd1, 32'd1, 3'b110);
      tick();
      chk("ctrl110_id", 64'(rsp_id), 64'd2);
      req_valid = 4'b0011;
      tick();
      chk("wrap_first", 64'(rsp_id), 64'd0);
      tick();
      chk("wrap_second", 64'(rsp_id), 64'd1);

      // A request withdrawn during a stall is never granted
      rsp_ready = 1'b0;
      req_valid = 4'b1000;
      tick();
      tick();
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      tick();
      chk("dropped_not_granted", 64'(rsp_id), 64'd0);
      req_valid = '0;
      tick();

      // Randomized phase honouring the requester stability rules
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (last_g == i || !req_valid[i]) begin
               logic [WIDTH-1:0] ra;
               ra = $urandom;
               set_req(i, 1'($urandom_range(0, 1)), ra,
                       ($urandom_range(0, 3) == 0) ? ra : 32'($urandom), 3'($urandom_range(0, 7)));
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
